// File: rtl/keypad_pkg.sv
// Shared keypad definitions: button codes, scanner state and the scan-candidate encoder.
package keypad_pkg;

  typedef enum logic [3:0] {
    STOP   = 4'hA,
    RESUME = 4'hB,
    UP     = 4'hC,
    DOWN   = 4'hD,
    ESCAPE = 4'hE,
    ENTER  = 4'hF
  } button_t;

  typedef enum logic {
    IDLE,
    HELD
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } cand_t;

  // Highest set key index wins; an empty snapshot yields an invalid candidate with code 0.
  function automatic cand_t encode_keys(input logic [15:0] snap);
    cand_t c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        c.valid = 1'b1;
        c.code  = 4'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the key-event bus towards the central FSM.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] buttonBus;
  logic       pressed;

  modport master (input rows, output cols, output buttonBus, output pressed);
  modport slave  (output rows, input cols, input buttonBus, input pressed);
endinterface

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, snapshot, debounce and one event strobe per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic nrst,
  keypad_scanner_if.master kp
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB         = 4'(DEBOUNCE);

  logic [DW-1:0] dwell_reg;
  logic [1:0]    col_reg;
  logic [15:0]   snap_reg;
  logic [15:0]   snap_next;
  cand_t         cand_reg;
  cand_t         cand_next;
  logic [3:0]    stab_reg;
  logic [3:0]    stab_next;
  scan_state_t   state_reg;
  logic          pressed_reg;
  logic [3:0]    code_reg;
  logic [3:0]    rows_sync;
  logic          dwell_done;
  logic          scan_end;

  row_sync #(.WIDTH(4)) u_row_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (kp.rows),
    .q    (rows_sync)
  );

  assign dwell_done = (dwell_reg == DWELL_LAST);
  assign scan_end   = dwell_done && (col_reg == 2'd3);

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    assign kp.cols[gi] = (col_reg == 2'(gi));
  end

  // Snapshot bit index equals the key code {row, col}.
  always_comb begin
    snap_next = snap_reg;
    if (dwell_done) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[r*4 + int'(col_reg)] = rows_sync[r];
      end
    end
  end

  assign cand_next = encode_keys(snap_next);

  always_comb begin
    stab_next = 4'd1;
    if (cand_next == cand_reg) begin
      stab_next = (stab_reg >= DB) ? DB : stab_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dwell_reg   <= '0;
      col_reg     <= '0;
      snap_reg    <= '0;
      cand_reg    <= '0;
      stab_reg    <= '0;
      state_reg   <= IDLE;
      pressed_reg <= 1'b0;
      code_reg    <= '0;
    end else begin
      pressed_reg <= 1'b0;
      code_reg    <= '0;
      if (dwell_done) begin
        dwell_reg <= '0;
        col_reg   <= col_reg + 2'd1;
        snap_reg  <= snap_next;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
      if (scan_end) begin
        cand_reg <= cand_next;
        stab_reg <= stab_next;
        case (state_reg)
          IDLE: begin
            if (stab_next == DB && cand_next.valid) begin
              state_reg   <= HELD;
              pressed_reg <= 1'b1;
              code_reg    <= cand_next.code;
            end
          end
          HELD: begin
            // Key changes while held are ignored until a debounced release.
            if (stab_next == DB && !cand_next.valid) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign kp.pressed   = pressed_reg;
  assign kp.buttonBus = code_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model, scan-level reference model and directed/random stimulus.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  rows_drv;

  int checks = 0;
  int errors = 0;
  int ev_count = 0;
  int ev_code = 0;
  int cyc = 0;

  // Reference model state
  int          e = 0;
  logic [15:0] kq[$];
  logic [15:0] msnap = '0;
  int          last_cand = -1;
  int          run = 0;
  bit          mheld = 0;
  int          exp_p = 0;
  int          exp_code = 0;
  int          exp_cols = 1;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk  (clk),
    .nrst (nrst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Physical matrix: a row reads 1 when any held key in that row sits in a driven column.
  always_comb begin
    rows_drv = '0;
    for (int r = 0; r < 4; r++) rows_drv[r] = |(keys[r*4 +: 4] & kp.cols);
  end
  assign kp.rows = rows_drv;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scan-level model: a column is read from the key state two edges before its sample edge.
  task automatic model_step();
    int col;
    int cand;
    if (!nrst) begin
      e = 0; kq.delete(); msnap = '0; last_cand = -1; run = 0; mheld = 0;
      exp_p = 0; exp_code = 0; exp_cols = 1;
    end else begin
      e++;
      kq.push_back(keys);
      if (kq.size() > 3) void'(kq.pop_front());
      exp_p = 0;
      exp_code = 0;
      if (e % SD == 0) begin
        col = (e / SD - 1) % 4;
        for (int r = 0; r < 4; r++) msnap[r*4 + col] = kq[0][r*4 + col];
      end
      if (e % (4*SD) == 0) begin
        cand = -1;
        for (int i = 0; i < 16; i++) if (msnap[i]) cand = i;
        if (cand == last_cand) run++;
        else begin run = 1; last_cand = cand; end
        if (!mheld && run >= DB && cand >= 0) begin
          mheld = 1; exp_p = 1; exp_code = cand;
        end else if (mheld && run >= DB && cand < 0) begin
          mheld = 0;
        end
      end
      exp_cols = 1 << ((e / SD) % 4);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #2;
      chk("pressed", int'(kp.pressed), exp_p);
      chk("buttonBus", int'(kp.buttonBus), exp_code);
      chk("cols", int'(kp.cols), exp_cols);
      if (kp.pressed) begin
        ev_count++;
        ev_code = int'(kp.buttonBus);
        $display("event code=%h cycle=%0d", kp.buttonBus, cyc);
      end
    end
  end

  task automatic wait_ev(input int max_cyc, output int lat);
    int start;
    start = ev_count;
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (ev_count != start) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    keys = k;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ev0;
    int lat;
    int sel;
    logic [15:0] k;

    // Reset and column rotation
    repeat (5) @(negedge clk);
    chk("rst_cols", int'(kp.cols), 1);
    chk("rst_pressed", int'(kp.pressed), 0);
    chk("rst_bus", int'(kp.buttonBus), 0);
    nrst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk("rotate", int'(kp.cols), 1 << ((n / 4) % 4));
    end
    hold(16'h0000, 60);

    // Single press of 0x5
    ev0 = ev_count;
    keys = 16'h0020;
    wait_ev(100, lat);
    chk("single_latency_ok", int'(lat >= 1 && lat <= 65), 1);
    hold(16'h0020, 150);
    chk("single_count", ev_count - ev0, 1);
    chk("single_code", ev_code, 5);
    hold(16'h0000, 100);

    // Bounce on 0xB, started at a fixed scan phase
    for (int i = 0; i < 16 && (e % 16) != 4; i++) @(negedge clk);
    ev0 = ev_count;
    for (int i = 0; i < 60; i++) begin
      keys = ((i / 7) % 2 == 0) ? 16'h0800 : 16'h0000;
      @(negedge clk);
    end
    chk("bounce_quiet", ev_count - ev0, 0);
    keys = 16'h0800;
    wait_ev(100, lat);
    chk("bounce_seen", int'(lat > 0), 1);
    hold(16'h0800, 50);
    chk("bounce_count", ev_count - ev0, 1);
    chk("bounce_code", ev_code, 16'hB);
    hold(16'h0000, 100);

    // Two keys together, then drop the higher one
    ev0 = ev_count;
    hold(16'h1008, 100);
    chk("dual_count", ev_count - ev0, 1);
    chk("dual_code", ev_code, 16'hC);
    hold(16'h0008, 100);
    chk("dual_drop_quiet", ev_count - ev0, 1);
    hold(16'h0000, 100);

    // Re-press with short then long release
    ev0 = ev_count;
    hold(16'h0200, 100);
    hold(16'h0000, 32);
    hold(16'h0200, 100);
    chk("repress_short", ev_count - ev0, 1);
    hold(16'h0000, 100);
    ev0 = ev_count;
    hold(16'h0200, 100);
    hold(16'h0000, 64);
    hold(16'h0200, 100);
    chk("repress_long", ev_count - ev0, 2);
    chk("repress_code", ev_code, 9);
    hold(16'h0000, 100);

    // Reset while held
    keys = 16'h8000;
    wait_ev(100, lat);
    chk("midrst_first", int'(lat > 0), 1);
    chk("midrst_code1", ev_code, 16'hF);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_cols", int'(kp.cols), 1);
    chk("midrst_pressed", int'(kp.pressed), 0);
    chk("midrst_bus", int'(kp.buttonBus), 0);
    nrst = 1'b1;
    ev0 = ev_count;
    wait_ev(80, lat);
    chk("midrst_latency_ok", int'(lat >= 1 && lat <= 65), 1);
    chk("midrst_code2", ev_code, 16'hF);
    hold(16'h0000, 100);

    // Randomized key activity checked cycle by cycle against the model
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      k = '0;
      if (sel == 1 || sel == 2) k[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) begin
        k[$urandom_range(0, 15)] = 1'b1;
        k[$urandom_range(0, 15)] = 1'b1;
      end
      hold(k, $urandom_range(1, 70));
    end
    hold(16'h0000, 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
